// File: rtl/leap_mem_arbiter.sv
// leap_mem_arbiter: round-robin share of one LEAP memory port among NUM_PORTS bus bridges
module leap_mem_arbiter #(
  parameter int NUM_PORTS      = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int IDX_WIDTH     = $clog2(NUM_PORTS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS-1:0]             up_write_req,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  up_write_data,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  up_write_addr,
  output logic [NUM_PORTS-1:0]             up_write_ack,
  input  logic [NUM_PORTS-1:0]             up_read_req,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  up_read_addr,
  output logic [NUM_PORTS-1:0]             up_read_ack,
  output logic [DATA_WIDTH-1:0]            up_read_data,
  output logic                             dn_write_req,
  output logic [DATA_WIDTH-1:0]            dn_write_data,
  output logic [ADDR_WIDTH-1:0]            dn_write_addr,
  input  logic                             dn_write_ack,
  output logic                             dn_read_req,
  output logic [ADDR_WIDTH-1:0]            dn_read_addr,
  input  logic                             dn_read_ack,
  input  logic [DATA_WIDTH-1:0]            dn_read_data,
  output logic [IDX_WIDTH-1:0]             grant_idx,
  output logic [NUM_PORTS-1:0]             timeout_err
);
  localparam int WD_WIDTH = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, WAIT_ACK, RELEASE} state_t;
  state_t                state, state_nxt;
  logic [IDX_WIDTH-1:0]  rr_ptr, win_idx, cand, nxt_ptr;
  logic [WD_WIDTH-1:0]   wd_cnt;
  logic [NUM_PORTS-1:0]  elig, grant_oh;
  logic                  win, wr_hit, rd_hit, hit, expire;
  assign elig     = up_write_req | up_read_req;
  assign grant_oh = NUM_PORTS'(1) << grant_idx;
  assign nxt_ptr  = grant_idx == IDX_WIDTH'(NUM_PORTS-1) ? '0 : grant_idx + 1'b1;
  // dn_write_req doubles as the op-type flag while a transaction is in flight
  assign wr_hit   = state == WAIT_ACK && dn_write_req && dn_write_ack;
  assign rd_hit   = state == WAIT_ACK && dn_read_req && dn_read_ack;
  assign hit      = wr_hit | rd_hit;
  assign expire   = state == WAIT_ACK && TIMEOUT_CYCLES != 0 && !hit &&
                    wd_cnt == WD_WIDTH'(TIMEOUT_CYCLES-1);
  assign up_write_ack = wr_hit ? grant_oh : '0;
  assign up_read_ack  = rd_hit ? grant_oh : '0;
  assign up_read_data = dn_read_data;
  // scan from the far end so the candidate closest to rr_ptr overwrites the rest
  always_comb begin
    win     = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = NUM_PORTS-1; k >= 0; k--) begin
      cand = IDX_WIDTH'((int'(rr_ptr) + k) % NUM_PORTS);
      if (elig[cand]) begin
        win     = 1'b1;
        win_idx = cand;
      end
    end
  end
  always_comb begin
    state_nxt = state;
    if (state == IDLE) state_nxt = win ? WAIT_ACK : IDLE;
    else if (state == WAIT_ACK) state_nxt = (hit || expire) ? RELEASE : WAIT_ACK;
    else state_nxt = IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_nxt;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr        <= '0;
      grant_idx     <= '0;
      dn_write_req  <= 1'b0;
      dn_read_req   <= 1'b0;
      dn_write_addr <= '0;
      dn_write_data <= '0;
      dn_read_addr  <= '0;
      timeout_err   <= '0;
      wd_cnt        <= '0;
    end else begin
      wd_cnt <= state == WAIT_ACK ? wd_cnt + 1'b1 : '0;
      if (state == IDLE && win) begin
        grant_idx    <= win_idx;
        dn_write_req <= up_write_req[win_idx];
        dn_read_req  <= !up_write_req[win_idx];
        if (up_write_req[win_idx]) begin
          dn_write_addr <= up_write_addr[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
          dn_write_data <= up_write_data[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
        end else dn_read_addr <= up_read_addr[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
      end
      if (hit || expire) begin
        dn_write_req <= 1'b0;
        dn_read_req  <= 1'b0;
        rr_ptr       <= nxt_ptr;
      end
      if (expire) timeout_err[grant_idx] <= 1'b1;
    end
  end
endmodule

// File: tb/tb_leap_mem_arbiter.sv
// tb_leap_mem_arbiter: directed checks of grant, ack routing, round-robin, watchdog and reset
module tb_leap_mem_arbiter;
  localparam int NP = 4;
  localparam int DW = 32;
  localparam int AW = 32;
  logic              clk = 1'b0;
  logic              rst;
  logic [NP-1:0]     up_write_req, up_write_ack, up_read_req, up_read_ack, timeout_err;
  logic [NP*DW-1:0]  up_write_data;
  logic [NP*AW-1:0]  up_write_addr, up_read_addr;
  logic [DW-1:0]     up_read_data, dn_write_data, dn_read_data;
  logic [AW-1:0]     dn_write_addr, dn_read_addr;
  logic              dn_write_req, dn_write_ack, dn_read_req, dn_read_ack;
  logic [1:0]        grant_idx;
  int                n_chk = 0;
  int                n_err = 0;
  logic [NP-1:0]     ack_seen;
  int                exp_rr [6] = '{0, 1, 3, 0, 1, 3};
  leap_mem_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .up_write_req(up_write_req), .up_write_data(up_write_data), .up_write_addr(up_write_addr),
    .up_write_ack(up_write_ack), .up_read_req(up_read_req), .up_read_addr(up_read_addr),
    .up_read_ack(up_read_ack), .up_read_data(up_read_data),
    .dn_write_req(dn_write_req), .dn_write_data(dn_write_data), .dn_write_addr(dn_write_addr),
    .dn_write_ack(dn_write_ack), .dn_read_req(dn_read_req), .dn_read_addr(dn_read_addr),
    .dn_read_ack(dn_read_ack), .dn_read_data(dn_read_data),
    .grant_idx(grant_idx), .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_grant(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (dn_write_req || dn_read_req) break;
      tick();
    end
    check(tag, 64'(dn_write_req | dn_read_req), 64'd1);
  endtask
  initial begin
    rst = 1'b1;
    up_write_req = '0; up_read_req = '0; up_write_data = '0; up_write_addr = '0; up_read_addr = '0;
    dn_write_ack = 1'b0; dn_read_ack = 1'b0; dn_read_data = '0;
    for (int i = 0; i < NP; i++) up_read_addr[i*AW +: AW] = 32'h10 * (i + 1);
    tick(); tick();
    check("rst_wreq", 64'(dn_write_req), 64'd0);
    check("rst_rreq", 64'(dn_read_req), 64'd0);
    check("rst_grant", 64'(grant_idx), 64'd0);
    check("rst_terr", 64'(timeout_err), 64'd0);
    check("rst_waddr", 64'(dn_write_addr), 64'd0);
    rst = 1'b0;
    tick();
    // round-robin among ports 0,1,3 with single-cycle acks
    up_read_req = 4'b1011;
    for (int g = 0; g < 6; g++) begin
      wait_grant($sformatf("rr_wait%0d", g));
      check($sformatf("rr_grant%0d", g), 64'(grant_idx), 64'(exp_rr[g]));
      check($sformatf("rr_addr%0d", g), 64'(dn_read_addr), 64'(32'h10 * (exp_rr[g] + 1)));
      dn_read_ack = 1'b1;
      #1;
      check($sformatf("rr_ack%0d", g), 64'(up_read_ack), 64'(4'b0001 << exp_rr[g]));
      tick();
      dn_read_ack = 1'b0;
      if (g == 5) up_read_req = '0;
    end
    tick();
    // single write from port 2, acked on the third WAIT_ACK cycle
    up_write_req = 4'b0100;
    up_write_addr[2*AW +: AW] = 32'h100;
    up_write_data[2*DW +: DW] = 32'hCAFE;
    #1;
    check("wr_req_early", 64'(dn_write_req), 64'd0);
    tick();
    check("wr_req_rise", 64'(dn_write_req), 64'd1);
    check("wr_grant", 64'(grant_idx), 64'd2);
    check("wr_addr", 64'(dn_write_addr), 64'h100);
    check("wr_data", 64'(dn_write_data), 64'hCAFE);
    dn_read_ack = 1'b1;
    #1;
    check("wrongtype_rack", 64'(up_read_ack), 64'd0);
    check("wrongtype_wack", 64'(up_write_ack), 64'd0);
    tick();
    dn_read_ack = 1'b0;
    check("wrongtype_hold", 64'(dn_write_req), 64'd1);
    tick();
    dn_write_ack = 1'b1;
    #1;
    check("wr_ack", 64'(up_write_ack), 64'b0100);
    tick();
    dn_write_ack = 1'b0;
    check("wr_release_req", 64'(dn_write_req), 64'd0);
    check("wr_release_ack", 64'(up_write_ack), 64'd0);
    up_write_req = '0;
    tick();
    // read data pass-through for port 1
    up_read_req = 4'b0010;
    up_read_addr[1*AW +: AW] = 32'h200;
    wait_grant("rd_wait");
    check("rd_grant", 64'(grant_idx), 64'd1);
    check("rd_addr", 64'(dn_read_addr), 64'h200);
    dn_read_data = 32'hDEADBEEF;
    dn_read_ack = 1'b1;
    #1;
    check("rd_ack", 64'(up_read_ack), 64'b0010);
    check("rd_data", 64'(up_read_data), 64'hDEADBEEF);
    tick();
    dn_read_ack = 1'b0;
    up_read_req = '0;
    tick();
    // watchdog: port 0 write never acked
    up_write_req = 4'b0001;
    ack_seen = '0;
    wait_grant("to_wait");
    check("to_grant", 64'(grant_idx), 64'd0);
    for (int i = 0; i < 7; i++) begin
      tick();
      ack_seen |= up_write_ack | up_read_ack;
    end
    check("to_still_req", 64'(dn_write_req), 64'd1);
    tick();
    check("to_req_drop", 64'(dn_write_req), 64'd0);
    check("to_err", 64'(timeout_err), 64'b0001);
    check("to_no_ack", 64'(ack_seen), 64'd0);
    up_write_req = 4'b0010;
    wait_grant("to_next_wait");
    check("to_next_grant", 64'(grant_idx), 64'd1);
    dn_write_ack = 1'b1;
    #1;
    check("to_next_ack", 64'(up_write_ack), 64'b0010);
    tick();
    dn_write_ack = 1'b0;
    up_write_req = '0;
    tick();
    // ack on the watchdog expiry cycle wins
    up_write_req = 4'b0100;
    wait_grant("exp_wait");
    for (int i = 0; i < 7; i++) tick();
    check("exp_still_req", 64'(dn_write_req), 64'd1);
    dn_write_ack = 1'b1;
    #1;
    check("exp_ack", 64'(up_write_ack), 64'b0100);
    tick();
    dn_write_ack = 1'b0;
    check("exp_terr", 64'(timeout_err), 64'b0001);
    check("exp_req_drop", 64'(dn_write_req), 64'd0);
    up_write_req = '0;
    tick();
    // asynchronous reset in the middle of a transaction
    up_write_req = 4'b1000;
    up_write_addr[3*AW +: AW] = 32'h3C0;
    wait_grant("ar_wait");
    check("ar_grant_pre", 64'(grant_idx), 64'd3);
    #2;
    rst = 1'b1;
    #1;
    check("ar_wreq", 64'(dn_write_req), 64'd0);
    check("ar_grant", 64'(grant_idx), 64'd0);
    check("ar_terr", 64'(timeout_err), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_grant("ar_post_wait");
    check("ar_post_grant", 64'(grant_idx), 64'd3);
    check("ar_post_addr", 64'(dn_write_addr), 64'h3C0);
    dn_write_ack = 1'b1;
    #1;
    check("ar_post_ack", 64'(up_write_ack), 64'b1000);
    tick();
    dn_write_ack = 1'b0;
    up_write_req = '0;
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
